// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the memory stage: register widths,
// access-length codes and the byte-transfer state machine encoding.
package stage_mem_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned LEN_W      = 3;

    localparam logic [LEN_W-1:0] MEM_LEN_B = 3'd1;
    localparam logic [LEN_W-1:0] MEM_LEN_H = 3'd2;
    localparam logic [LEN_W-1:0] MEM_LEN_W = 3'd4;

    typedef enum logic [1:0] {
        MEM_ST_IDLE,
        MEM_ST_XFER,
        MEM_ST_WAIT,
        MEM_ST_DONE
    } mem_state_t;

    // Any length code other than byte or half is handled as a full word.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == MEM_LEN_B || len == MEM_LEN_H) ? len : MEM_LEN_W;
    endfunction

endpackage

// File: rtl/stage_mem_load_ext.sv
// Load result extension: zero/sign-extends the assembled load bytes
// to the register width according to the access length.
module mem_load_ext
    import stage_mem_pkg::*;
(
    input  logic [REG_W-1:0] buf_data,
    input  logic [LEN_W-1:0] mem_length,
    input  logic             mem_signed,
    output logic [REG_W-1:0] ext_data
);

    always_comb begin
        case (eff_len(mem_length))
            MEM_LEN_B: ext_data = {{24{mem_signed & buf_data[7]}},  buf_data[7:0]};
            MEM_LEN_H: ext_data = {{16{mem_signed & buf_data[15]}}, buf_data[15:0]};
            default:   ext_data = buf_data;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory stage: serialises loads/stores into byte transfers on an 8-bit
// RAM port, assembles load data and forwards the register write to WB.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MAX_LEN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_i,
    input  logic [REG_ADDR_W-1:0] regw_addr_i,
    input  logic [REG_W-1:0]      regw_data_i,
    input  logic                  load,
    input  logic                  store,
    input  logic [LEN_W-1:0]      mem_length,
    input  logic                  mem_signed,
    input  logic [REG_W-1:0]      mem_write_data,
    output logic                  stall_mem,
    output logic                  write_o,
    output logic [REG_ADDR_W-1:0] regw_addr_o,
    output logic [REG_W-1:0]      regw_data_o,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic                  ram_grant,
    input  logic [7:0]            ram_rdata
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN);
    localparam int unsigned CNT_W = IDX_W + 1;

    mem_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [REG_W-1:0]   asm_buf;
    logic               rd_pend;
    logic [IDX_W-1:0]   rd_idx;

    logic               access;
    logic               is_load;
    logic               last;
    logic [LEN_W-1:0]   len_eff;
    logic [IDX_W-1:0]   idx;
    logic [REG_W-1:0]   load_data;

    assign access  = load | store;
    assign is_load = load;
    assign len_eff = eff_len(mem_length);
    assign last    = (cnt == CNT_W'(len_eff - 3'd1));
    assign idx     = cnt[IDX_W-1:0];

    mem_load_ext u_load_ext (
        .buf_data   (asm_buf),
        .mem_length (mem_length),
        .mem_signed (mem_signed),
        .ext_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= MEM_ST_IDLE;
            cnt     <= '0;
            asm_buf <= '0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            // Read data arrives one cycle after its grant; rd_idx keeps its byte lane.
            rd_pend <= 1'b0;
            if (rd_pend)
                asm_buf[8*rd_idx +: 8] <= ram_rdata;

            case (state)
                MEM_ST_IDLE, MEM_ST_XFER: begin
                    if (access) begin
                        if (ram_grant) begin
                            cnt     <= cnt + CNT_W'(1);
                            rd_pend <= is_load;
                            rd_idx  <= idx;
                            if (last)
                                state <= is_load ? MEM_ST_WAIT : MEM_ST_DONE;
                            else
                                state <= MEM_ST_XFER;
                        end
                    end else begin
                        state <= MEM_ST_IDLE;
                        cnt   <= '0;
                    end
                end
                MEM_ST_WAIT: state <= MEM_ST_DONE;
                MEM_ST_DONE: begin
                    cnt   <= '0;
                    state <= MEM_ST_IDLE;
                end
                default: state <= MEM_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_mem   = 1'b0;
        write_o     = 1'b0;
        regw_addr_o = '0;
        regw_data_o = '0;
        ram_req     = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        if (reset) begin
            if (!access) begin
                write_o     = write_i;
                regw_addr_o = regw_addr_i;
                regw_data_o = regw_data_i;
            end else begin
                regw_addr_o = regw_addr_i;
                case (state)
                    MEM_ST_IDLE, MEM_ST_XFER: begin
                        stall_mem = 1'b1;
                        ram_req   = 1'b1;
                        ram_we    = store & ~load;
                        ram_addr  = ADDR_W'(regw_data_i) + ADDR_W'(cnt);
                        ram_wdata = mem_write_data[8*idx +: 8];
                    end
                    MEM_ST_WAIT: stall_mem = 1'b1;
                    MEM_ST_DONE: begin
                        write_o     = write_i;
                        regw_data_o = is_load ? load_data : regw_data_i;
                    end
                    default: stall_mem = 1'b1;
                endcase
            end
        end
    end

endmodule
